// File: rtl/gemm_scratchpad_if.sv
// Scratchpad port bundle: CPU dbus, stream control and vector output.
interface gemm_scratchpad_if #(
  parameter int DEPTH      = 128,
  parameter int ROWS       = 16,
  parameter int A_BITWIDTH = 8
);
  localparam int LB     = $clog2(DEPTH);
  localparam int LINE_W = ROWS * A_BITWIDTH;

  logic              dbus_en;
  logic              dbus_rdwr;
  logic [3:0]        dbus_mask;
  logic [31:0]       dbus_addr;
  logic [31:0]       dbus_wr_data;
  logic [31:0]       dbus_rd_data;
  logic              dbus_rd_valid;
  logic              dbus_stall;

  logic              strm_start;
  logic [LB-1:0]     strm_line;
  logic [LB:0]       strm_count;
  logic              strm_skew;
  logic              strm_busy;
  logic              strm_done;

  logic              vec_valid;
  logic              vec_ready;
  logic [LINE_W-1:0] vec_data;
  logic              vec_last;

  modport master (
    output dbus_en, dbus_rdwr, dbus_mask,
    output dbus_addr, dbus_wr_data,
    input  dbus_rd_data, dbus_rd_valid, dbus_stall,
    output strm_start, strm_line, strm_count,
    output strm_skew,
    input  strm_busy, strm_done,
    input  vec_valid, vec_data, vec_last,
    output vec_ready
  );

  modport slave (
    input  dbus_en, dbus_rdwr, dbus_mask,
    input  dbus_addr, dbus_wr_data,
    output dbus_rd_data, dbus_rd_valid, dbus_stall,
    input  strm_start, strm_line, strm_count,
    input  strm_skew,
    output strm_busy, strm_done,
    output vec_valid, vec_data, vec_last,
    input  vec_ready
  );
endinterface

// File: rtl/gemm_scratchpad.sv
// GEMM operand scratchpad: byte-masked CPU fill, streamed
// line replay to the systolic array with optional diagonal skew.
module gemm_scratchpad #(
  parameter int DEPTH      = 128,
  parameter int ROWS       = 16,
  parameter int A_BITWIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  gemm_scratchpad_if.slave bus
);
  localparam int LINE_W = ROWS * A_BITWIDTH;
  localparam int WPL    = LINE_W / 32;
  localparam int LB     = $clog2(DEPTH);
  localparam int WB     = $clog2(WPL);
  localparam int WBX    = (WB > 0) ? WB : 1;
  localparam int KW     = $clog2(DEPTH + ROWS) + 1;
  localparam int NBY    = LINE_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic              busy, done;
  logic              start_acc, advance;
  logic              produce, last_xfer;
  logic              cpu_acc, cpu_wr, cpu_rd;
  logic [WBX-1:0]    word_sel;
  logic [LB-1:0]     line_sel;
  logic [NBY-1:0]    be;
  logic [LINE_W-1:0] wr_line, cpu_line;
  logic [31:0]       cpu_word;
  logic [31:0]       rd_data_q;
  logic              rd_valid_q;

  logic [KW-1:0]     beat_cnt, total;
  logic [LB-1:0]     rd_line;
  logic [LB:0]       cnt_q;
  logic              skew_q;
  logic              vld_q, last_q;
  logic [LINE_W-1:0] data_q;
  logic [LINE_W-1:0] in_line, skew_out;

  logic [LINE_W-1:0] mem [DEPTH];

  logic unused_addr;
  assign unused_addr = ^{bus.dbus_addr[31:2+WB+LB],
                         bus.dbus_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (bus.strm_start)
          state_nx = (bus.strm_count == '0) ? S_DONE
                                            : S_STREAM;
      S_STREAM:
        if (last_xfer) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    unique case (state)
      S_IDLE:  busy = 1'b0;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.strm_busy  = busy;
  assign bus.strm_done  = done;
  assign bus.dbus_stall = busy;

  // CPU port: word/byte select decoded to a per-byte line enable
  assign cpu_acc  = bus.dbus_en && !busy;
  assign cpu_wr   = cpu_acc && bus.dbus_rdwr;
  assign cpu_rd   = cpu_acc && !bus.dbus_rdwr;
  assign word_sel = (WPL == 1) ? '0 : bus.dbus_addr[2 +: WBX];
  assign line_sel = bus.dbus_addr[2+WB +: LB];
  assign wr_line  = {WPL{bus.dbus_wr_data}};

  always_comb begin
    be = '0;
    for (int i = 0; i < NBY; i++)
      be[i] = (i / 4 == int'(word_sel))
           && bus.dbus_mask[i % 4];
  end

  always_ff @(posedge clk) begin
    if (cpu_wr)
      for (int i = 0; i < NBY; i++)
        if (be[i])
          mem[line_sel][i*8 +: 8] <= wr_line[i*8 +: 8];
  end

  always_comb begin
    cpu_line = mem[line_sel];
    cpu_word = '0;
    for (int w = 0; w < WPL; w++)
      if (w == int'(word_sel))
        cpu_word = cpu_line[w*32 +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= cpu_rd;
      if (cpu_rd) rd_data_q <= cpu_word;
    end
  end

  assign bus.dbus_rd_data  = rd_data_q;
  assign bus.dbus_rd_valid = rd_valid_q;

  // Stream engine: output register refills whenever it is
  // empty or its beat is being taken.
  assign start_acc = (state == S_IDLE) && bus.strm_start;
  assign advance   = !vld_q || bus.vec_ready;
  assign total     = KW'(cnt_q)
                   + (skew_q ? KW'(ROWS - 1) : KW'(0));
  assign produce   = (state == S_STREAM) && advance
                  && (beat_cnt != total);
  assign last_xfer = vld_q && bus.vec_ready && last_q;
  assign in_line   = (beat_cnt < KW'(cnt_q)) ? mem[rd_line]
                                             : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      beat_cnt <= '0;
      rd_line  <= '0;
      cnt_q    <= '0;
      skew_q   <= 1'b0;
    end else if (start_acc) begin
      rd_line  <= bus.strm_line;
      cnt_q    <= bus.strm_count;
      skew_q   <= bus.strm_skew;
      beat_cnt <= '0;
    end else if (state == S_STREAM && advance) begin
      vld_q  <= produce;
      last_q <= produce && (beat_cnt == total - KW'(1));
      if (produce) begin
        data_q   <= skew_q ? skew_out : in_line;
        beat_cnt <= beat_cnt + 1'b1;
        rd_line  <= rd_line + 1'b1;
      end
    end
  end

  // Row r sees the line fetched r beats earlier; zero-filled
  // at start so leading/trailing diagonal slots read as 0.
  assign skew_out[0 +: A_BITWIDTH] = in_line[0 +: A_BITWIDTH];

  for (genvar r = 1; r < ROWS; r++) begin : g_row
    logic [A_BITWIDTH-1:0] dl [r];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < r; j++) dl[j] <= '0;
      end else if (start_acc) begin
        for (int j = 0; j < r; j++) dl[j] <= '0;
      end else if (produce) begin
        dl[0] <= in_line[r*A_BITWIDTH +: A_BITWIDTH];
        for (int j = 1; j < r; j++) dl[j] <= dl[j-1];
      end
    end

    assign skew_out[r*A_BITWIDTH +: A_BITWIDTH] = dl[r-1];
  end

  assign bus.vec_valid = vld_q;
  assign bus.vec_last  = last_q;
  assign bus.vec_data  = data_q;
endmodule

// File: tb/tb_gemm_scratchpad.sv
// Randomised bench for gemm_scratchpad against a line-array
// reference model with spec-level beat construction.
module tb_gemm_scratchpad;
  localparam int DEPTH  = 128;
  localparam int ROWS   = 16;
  localparam int AW     = 8;
  localparam int LINE_W = ROWS * AW;
  localparam int WPL    = LINE_W / 32;
  localparam int LB     = $clog2(DEPTH);
  localparam int WB     = $clog2(WPL);
  localparam int OW     = LINE_W + 38;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gemm_scratchpad_if #(
    .DEPTH(DEPTH), .ROWS(ROWS), .A_BITWIDTH(AW)
  ) bus ();

  gemm_scratchpad #(
    .DEPTH(DEPTH), .ROWS(ROWS), .A_BITWIDTH(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [LINE_W-1:0] mdl [DEPTH];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] all_outs();
    return {bus.dbus_rd_data, bus.dbus_rd_valid,
            bus.dbus_stall, bus.strm_busy, bus.strm_done,
            bus.vec_valid, bus.vec_last, bus.vec_data};
  endfunction

  function automatic logic [31:0] mk_addr(int line, int word);
    logic [31:0] a;
    a = $urandom();
    a[2 +: WB]    = word[WB-1:0];
    a[2+WB +: LB] = line[LB-1:0];
    return a;
  endfunction

  task automatic cpu_write(int line, int word,
                           logic [3:0] mask, logic [31:0] d);
    bus.dbus_en      = 1'b1;
    bus.dbus_rdwr    = 1'b1;
    bus.dbus_mask    = mask;
    bus.dbus_addr    = mk_addr(line, word);
    bus.dbus_wr_data = d;
    step();
    bus.dbus_en   = 1'b0;
    bus.dbus_rdwr = 1'b0;
    for (int b = 0; b < 4; b++)
      if (mask[b])
        mdl[line][word*32 + b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic cpu_read(int line, int word,
                          output logic [31:0] d,
                          output logic v);
    bus.dbus_en   = 1'b1;
    bus.dbus_rdwr = 1'b0;
    bus.dbus_addr = mk_addr(line, word);
    step();
    bus.dbus_en = 1'b0;
    d = bus.dbus_rd_data;
    v = bus.dbus_rd_valid;
  endtask

  task automatic fill_rand(int line);
    for (int w = 0; w < WPL; w++)
      cpu_write(line, w, 4'hf, $urandom());
  endtask

  task automatic fill_all();
    for (int l = 0; l < DEPTH; l++) fill_rand(l);
  endtask

  // mode 0: ready high, 1: 1,0,0 repeating, 2: random
  task automatic run_stream(string nm, int line, int count,
                            bit skew, int mode);
    logic [LINE_W-1:0] exp_q [$];
    logic [LINE_W-1:0] v, hold_d;
    logic hold_l;
    bit stalled, done_seen, rdy;
    int nb, idx, cyc, last_cyc;
    nb = (count == 0) ? 0 : (skew ? count + ROWS - 1 : count);
    for (int k = 0; k < nb; k++) begin
      v = '0;
      for (int r = 0; r < ROWS; r++) begin
        int s;
        s = skew ? k - r : k;
        if (s >= 0 && s < count)
          v[r*AW +: AW] = mdl[(line + s) % DEPTH][r*AW +: AW];
      end
      exp_q.push_back(v);
    end
    bus.strm_line  = line[LB-1:0];
    bus.strm_count = count[LB:0];
    bus.strm_skew  = skew;
    bus.strm_start = 1'b1;
    bus.vec_ready  = 1'b1;
    step();
    bus.strm_start = 1'b0;
    idx = 0; cyc = 0; last_cyc = -1;
    stalled = 0; done_seen = 0;
    hold_d = '0; hold_l = 0;
    checks++;
    if (bus.vec_valid !== 1'b0 || bus.strm_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s t1: valid=%b busy=%b want 0 1",
               nm, bus.vec_valid, bus.strm_busy);
    end
    while (!done_seen && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.vec_ready = rdy;
      if (cyc == 1) begin
        checks++;
        if (bus.vec_valid !== (nb > 0)) begin
          errors++;
          $display("FAIL %s latency: valid=%b want %b",
                   nm, bus.vec_valid, nb > 0);
        end
      end
      if (bus.vec_valid === 1'b1) begin
        if (stalled) begin
          checks++;
          if (bus.vec_data !== hold_d ||
              bus.vec_last !== hold_l) begin
            errors++;
            $display("FAIL %s hold: got %h/%b want %h/%b",
                     nm, bus.vec_data, bus.vec_last,
                     hold_d, hold_l);
          end
        end
        if (rdy) begin
          checks++;
          if (idx >= nb) begin
            errors++;
            $display("FAIL %s extra beat: got %0d want %0d",
                     nm, idx + 1, nb);
          end else if (bus.vec_data !== exp_q[idx] ||
                       bus.vec_last !== (idx == nb - 1)) begin
            errors++;
            $display("FAIL %s beat%0d: got %h/%b want %h/%b",
                     nm, idx, bus.vec_data, bus.vec_last,
                     exp_q[idx], idx == nb - 1);
          end
          if (idx == nb - 1) last_cyc = cyc;
          idx++;
        end
      end
      stalled = bus.vec_valid && !rdy;
      hold_d  = bus.vec_data;
      hold_l  = bus.vec_last;
      if (bus.strm_done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (idx != nb || cyc != last_cyc + 1) begin
          errors++;
          $display("FAIL %s done: beats %0d at cyc %0d want %0d at %0d",
                   nm, idx, cyc, nb, last_cyc + 1);
        end
      end
      step();
      cyc++;
    end
    checks++;
    if (!done_seen || bus.strm_busy !== 1'b0 ||
        bus.dbus_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s end: done=%b busy=%b want 1 0",
               nm, done_seen, bus.strm_busy);
    end
    bus.vec_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h want 0", all_outs());
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_release: got %h want 0", all_outs());
    end
  endtask

  task automatic test_masked_rw();
    logic [31:0] d;
    logic v;
    cpu_write(3, 1, 4'b1111, 32'hAABBCCDD);
    cpu_write(3, 1, 4'b0101, 32'h11223344);
    cpu_read(3, 1, d, v);
    checks++;
    if (d !== 32'hAA22CC44 || v !== 1'b1) begin
      errors++;
      $display("FAIL masked_rd: got %h/%b want aa22cc44/1", d, v);
    end
    step();
    checks++;
    if (bus.dbus_rd_valid !== 1'b0 ||
        bus.dbus_rd_data !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL rd_hold: got %h/%b want aa22cc44/0",
               bus.dbus_rd_data, bus.dbus_rd_valid);
    end
    for (int i = 0; i < 24; i++) begin
      int l, w, w2;
      l  = $urandom_range(0, DEPTH - 1);
      w  = $urandom_range(0, WPL - 1);
      w2 = (i % 2 == 0) ? w : $urandom_range(0, WPL - 1);
      cpu_write(l, w, 4'($urandom_range(0, 15)), $urandom());
      cpu_read(l, w2, d, v);
      checks++;
      if (d !== mdl[l][w2*32 +: 32] || v !== 1'b1) begin
        errors++;
        $display("FAIL rand_rw l%0d w%0d: got %h want %h",
                 l, w2, d, mdl[l][w2*32 +: 32]);
      end
    end
  endtask

  task automatic fill_ramp(int l);
    logic [LINE_W-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*AW +: AW] = AW'(16*l + r);
    for (int w = 0; w < WPL; w++)
      cpu_write(l, w, 4'hf, v[w*32 +: 32]);
  endtask

  task automatic test_plain_stream();
    for (int l = 0; l < 4; l++) fill_ramp(l);
    run_stream("plain", 0, 4, 1'b0, 0);
  endtask

  task automatic test_skew_stream();
    run_stream("skew", 0, 2, 1'b1, 0);
  endtask

  task automatic test_backpressure_wrap();
    run_stream("wrap", DEPTH - 2, 4, 1'b0, 1);
  endtask

  task automatic test_count_zero();
    run_stream("zero", 5, 0, 1'b0, 0);
  endtask

  task automatic test_cpu_block();
    logic [31:0] d, rd;
    logic v;
    int idx, cyc;
    bus.strm_line  = 7'd8;
    bus.strm_count = 8'd8;
    bus.strm_skew  = 1'b0;
    bus.strm_start = 1'b1;
    bus.vec_ready  = 1'b1;
    bus.dbus_en    = 1'b1;
    bus.dbus_rdwr  = 1'b0;
    bus.dbus_addr  = mk_addr(50, 0);
    step();
    bus.strm_start = 1'b0;
    checks++;
    if (bus.dbus_rd_valid !== 1'b1 ||
        bus.dbus_rd_data !== mdl[50][31:0]) begin
      errors++;
      $display("FAIL start_rd: got %h/%b want %h/1",
               bus.dbus_rd_data, bus.dbus_rd_valid,
               mdl[50][31:0]);
    end
    d = $urandom();
    bus.dbus_rdwr    = 1'b1;
    bus.dbus_mask    = 4'hf;
    bus.dbus_addr    = mk_addr(50, 2);
    bus.dbus_wr_data = d;
    idx = 0; cyc = 0;
    while (bus.strm_busy === 1'b1 && cyc < 100) begin
      checks++;
      if (bus.dbus_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got %b want 1", bus.dbus_stall);
      end
      if (bus.vec_valid === 1'b1) begin
        checks++;
        if (bus.vec_data !== mdl[8 + idx]) begin
          errors++;
          $display("FAIL block_beat%0d: got %h want %h",
                   idx, bus.vec_data, mdl[8 + idx]);
        end
        idx++;
      end
      step();
      cyc++;
    end
    checks++;
    if (bus.strm_busy !== 1'b0 || bus.dbus_stall !== 1'b0 ||
        idx != 8) begin
      errors++;
      $display("FAIL block_end: busy=%b stall=%b beats=%0d want 0 0 8",
               bus.strm_busy, bus.dbus_stall, idx);
    end
    step();
    bus.dbus_en   = 1'b0;
    bus.dbus_rdwr = 1'b0;
    mdl[50][64 +: 32] = d;
    cpu_read(50, 2, rd, v);
    checks++;
    if (rd !== d || v !== 1'b1) begin
      errors++;
      $display("FAIL late_write: got %h/%b want %h/1", rd, v, d);
    end
  endtask

  task automatic test_reset_mid();
    int seen, cyc;
    bus.strm_line  = 7'd20;
    bus.strm_count = 8'd8;
    bus.strm_skew  = 1'b0;
    bus.strm_start = 1'b1;
    bus.vec_ready  = 1'b1;
    step();
    bus.strm_start = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 50) begin
      if (bus.vec_valid === 1'b1) seen++;
      step();
      cyc++;
    end
    checks++;
    if (bus.vec_valid !== 1'b1 || seen != 2) begin
      errors++;
      $display("FAIL mid_beat2: valid=%b seen=%0d want 1 2",
               bus.vec_valid, seen);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %h want 0", all_outs());
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int l = 20; l < 28; l++) fill_rand(l);
    run_stream("post_reset", 20, 8, 1'b1, 2);
  endtask

  task automatic test_random();
    fill_all();
    for (int i = 0; i < 8; i++) begin
      run_stream("rand", $urandom_range(0, DEPTH - 1),
                 $urandom_range(1, 20),
                 1'($urandom_range(0, 1)), 2);
    end
    run_stream("full", 3, DEPTH, 1'b1, 2);
  endtask

  initial begin
    bus.dbus_en      = 1'b0;
    bus.dbus_rdwr    = 1'b0;
    bus.dbus_mask    = 4'h0;
    bus.dbus_addr    = '0;
    bus.dbus_wr_data = '0;
    bus.strm_start   = 1'b0;
    bus.strm_line    = '0;
    bus.strm_count   = '0;
    bus.strm_skew    = 1'b0;
    bus.vec_ready    = 1'b1;
    test_reset();
    fill_all();
    test_masked_rw();
    test_plain_stream();
    test_skew_stream();
    test_backpressure_wrap();
    test_count_zero();
    test_cpu_block();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
